// File: rtl/conv_seq_pkg.sv
// ---------------------------------------------------------------------------
// conv_seq_pkg
//   Shared types and elaboration-time helpers for the convolution tile
//   sequencer: the FSM state encoding and the output-count / tile-count
//   calculations used to size counters and detect the last tile.
// ---------------------------------------------------------------------------
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        FIN
    } state_e;

    // Number of valid convolution outputs (no padding).
    function automatic int calc_size(input int lenx, input int lenf);
        return lenx - lenf + 1;
    endfunction

    // Number of P-lane tiles needed to cover all outputs (ceiling divide).
    function automatic int calc_ntiles(input int size, input int p);
        return (size + p - 1) / p;
    endfunction

endpackage

// File: rtl/conv_seq_lane_addr.sv
// ---------------------------------------------------------------------------
// conv_seq_lane_addr
//   Combinational per-lane x address generator. Lane i reads x[base+i+k],
//   clamped to the last x entry so over-range lanes never address outside
//   the buffer. lane_valid marks lanes whose output index is a real output.
// Ports
//   base_i        in   ADDRX      first output index of the tile (t*P)
//   k_i           in   ADDRF      current filter tap
//   addr_x_o      out  P*ADDRX    lane i address at [i*ADDRX +: ADDRX]
//   lane_valid_o  out  P          lane i holds a real output
// ---------------------------------------------------------------------------
module conv_seq_lane_addr #(
    parameter int LENX  = 24,
    parameter int SIZE  = 15,
    parameter int P     = 5,
    parameter int ADDRX = 5,
    parameter int ADDRF = 4
) (
    input  logic [ADDRX-1:0]   base_i,
    input  logic [ADDRF-1:0]   k_i,
    output logic [P*ADDRX-1:0] addr_x_o,
    output logic [P-1:0]       lane_valid_o
);

    int lane_idx;
    int raw_addr;

    // NOTE: every variable driven here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        addr_x_o     = '0;
        lane_valid_o = '0;
        lane_idx     = 0;
        raw_addr     = 0;
        for (int i = 0; i < P; i++) begin
            lane_idx = int'(base_i) + i;
            raw_addr = lane_idx + int'(k_i);
            // Clamped lanes accumulate garbage; lane_valid tells the op
            // memory to drop them.
            addr_x_o[i*ADDRX +: ADDRX] = (raw_addr > LENX - 1) ? ADDRX'(LENX - 1)
                                                                : ADDRX'(raw_addr);
            lane_valid_o[i] = (lane_idx < SIZE);
        end
    end

endmodule

// File: rtl/conv_tile_sequencer.sv
// ---------------------------------------------------------------------------
// conv_tile_sequencer
//   Control sequencer for a P-lane convolution datapath. Once the x buffer is
//   full (start), it walks SIZE outputs in tiles of P lanes. Per tile it
//   issues LENF x/f address sets, produces en_acc/clr_acc one cycle later to
//   match the 1-cycle memory read latency, then presents a tile write to the
//   op memory and waits for out_ready.
//   Tile time with no stall: LENF (ISSUE) + 1 (DRAIN) + 1 (WRITE) cycles.
// Optional feature macro: CONV_SEQ_PERF_EN adds perf_cycles/perf_stalls.
// Ports
//   clk, reset      clock and synchronous active-high reset
//   start           x buffer full, only sampled in IDLE
//   out_ready       op memory accepts a tile write
//   busy            FSM not in IDLE
//   m_addr_read_x   per-lane x read address (0 outside ISSUE)
//   m_addr_read_f   shared f ROM read address (0 outside ISSUE)
//   en_acc/clr_acc  MAC accumulate enable / first-product load
//   valid_op        tile write strobe
//   out_base_addr   t*P of the current tile
//   lane_valid      lanes with real outputs in this tile
//   perf_cycles     (CONV_SEQ_PERF_EN) tile-processing cycles, saturating
//   perf_stalls     (CONV_SEQ_PERF_EN) WRITE cycles with out_ready=0
//   done            one-cycle pulse after the last tile write
// ---------------------------------------------------------------------------
module conv_tile_sequencer
    import conv_seq_pkg::*;
#(
    parameter int LENX  = 24,
    parameter int LENF  = 10,
    parameter int P     = 5,
    parameter int ADDRX = 5,
    parameter int ADDRF = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               out_ready,
    output logic               busy,
    output logic [P*ADDRX-1:0] m_addr_read_x,
    output logic [ADDRF-1:0]   m_addr_read_f,
    output logic               en_acc,
    output logic               clr_acc,
    output logic               valid_op,
    output logic [ADDRX-1:0]   out_base_addr,
    output logic [P-1:0]       lane_valid,
`ifdef CONV_SEQ_PERF_EN
    output logic [15:0]        perf_cycles,
    output logic [15:0]        perf_stalls,
`endif
    output logic               done
);

    localparam int SIZE   = calc_size(LENX, LENF);
    localparam int NTILES = calc_ntiles(SIZE, P);

    state_e             state_q, state_d;
    logic [ADDRX-1:0]   t_q, t_d;
    logic [ADDRF-1:0]   k_q, k_d;
    logic               en_acc_q, clr_acc_q;

    logic [ADDRX-1:0]   base;
    logic [P*ADDRX-1:0] lane_addr;
    logic [P-1:0]       lane_ok;
    logic               issuing;
    logic               working;

    assign base    = ADDRX'(t_q * P);
    assign issuing = (state_q == ISSUE);
    assign working = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == WRITE);

    conv_seq_lane_addr #(
        .LENX  (LENX),
        .SIZE  (SIZE),
        .P     (P),
        .ADDRX (ADDRX),
        .ADDRF (ADDRF)
    ) u_lane_addr (
        .base_i       (base),
        .k_i          (k_q),
        .addr_x_o     (lane_addr),
        .lane_valid_o (lane_ok)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    t_d     = '0;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                if (k_q == ADDRF'(LENF - 1)) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                // Counters hold while the op memory back-pressures.
                if (out_ready) begin
                    if (t_q == ADDRX'(NTILES - 1)) begin
                        state_d = FIN;
                    end else begin
                        t_d     = t_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                t_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CONV_SEQ_PERF_EN
    logic [15:0] perf_cycles_q, perf_stalls_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            t_q       <= '0;
            k_q       <= '0;
            en_acc_q  <= 1'b0;
            clr_acc_q <= 1'b0;
`ifdef CONV_SEQ_PERF_EN
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            k_q       <= k_d;
            // Accumulate enables trail the address issue by the read latency.
            en_acc_q  <= issuing;
            clr_acc_q <= issuing && (k_q == '0);
`ifdef CONV_SEQ_PERF_EN
            if ((state_q == IDLE) && start) begin
                perf_cycles_q <= '0;
                perf_stalls_q <= '0;
            end else begin
                // The FIN handshake is not tile work, so a stall-free pass
                // reports exactly NTILES*(LENF+2).
                if (working && (perf_cycles_q != 16'hFFFF)) begin
                    perf_cycles_q <= perf_cycles_q + 16'd1;
                end
                if ((state_q == WRITE) && !out_ready && (perf_stalls_q != 16'hFFFF)) begin
                    perf_stalls_q <= perf_stalls_q + 16'd1;
                end
            end
`endif
        end
    end

    assign busy          = (state_q != IDLE);
    assign valid_op      = (state_q == WRITE) && out_ready;
    assign done          = (state_q == FIN);
    assign en_acc        = en_acc_q;
    assign clr_acc       = clr_acc_q;
    assign out_base_addr = base;
    assign m_addr_read_f = issuing ? k_q : '0;
    assign m_addr_read_x = issuing ? lane_addr : '0;
    assign lane_valid    = working ? lane_ok : '0;

`ifdef CONV_SEQ_PERF_EN
    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule
